// File: rtl/v_pkg.sv
// Shared RVV encoding constants, instruction-class enum and legality/opcode helpers
// used by the vector instruction encoder.
package v_pkg;

   localparam logic [6:0] OPC_LTYPE = 7'h07;
   localparam logic [6:0] OPC_STYPE = 7'h27;
   localparam logic [6:0] OPC_RTYPE = 7'h57;

   localparam logic [2:0] OPI_VV = 3'b000;
   localparam logic [2:0] OPM_VV = 3'b010;
   localparam logic [2:0] OPI_VI = 3'b011;
   localparam logic [2:0] OPI_VX = 3'b100;
   localparam logic [2:0] OPM_VX = 3'b110;

   localparam logic [1:0] MOP_UNIT   = 2'b00;
   localparam logic [1:0] MOP_IDX_U  = 2'b01;
   localparam logic [1:0] MOP_STRIDE = 2'b10;
   localparam logic [1:0] MOP_IDX_O  = 2'b11;

   localparam logic [2:0] VW_8  = 3'b000;
   localparam logic [2:0] VW_16 = 3'b101;
   localparam logic [2:0] VW_32 = 3'b110;
   localparam logic [2:0] VW_64 = 3'b111;

   typedef enum logic [1:0] {
      VC_LOAD  = 2'b00,
      VC_STORE = 2'b01,
      VC_ARITH = 2'b10,
      VC_RSVD  = 2'b11
   } v_class_e;

   // Only operand types / widths the coprocessor decoder implements are accepted.
   function automatic logic is_legal(input v_class_e cls, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (cls)
         VC_ARITH: ok = (f3 == OPI_VV) || (f3 == OPM_VV) || (f3 == OPI_VI) ||
                        (f3 == OPI_VX) || (f3 == OPM_VX);
         VC_LOAD,
         VC_STORE: ok = (f3 == VW_8) || (f3 == VW_16) || (f3 == VW_32) || (f3 == VW_64);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [6:0] class_opcode(input v_class_e cls);
      logic [6:0] opc;
      opc = OPC_RTYPE;
      case (cls)
         VC_LOAD:  opc = OPC_LTYPE;
         VC_STORE: opc = OPC_STYPE;
         VC_ARITH: opc = OPC_RTYPE;
         default:  opc = OPC_RTYPE;
      endcase
      return opc;
   endfunction

endpackage

// File: rtl/v_instr_fifo.sv
// Synchronous circular-buffer FIFO for assembled instruction words. Pointers carry one
// extra MSB so full and empty are distinguishable; storage clears on reset.
module v_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       wr_en,
   input  logic [W-1:0]               wr_data,
   input  logic                       rd_en,
   output logic [W-1:0]               rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] mem_r [DEPTH];
   logic [AW:0]  wr_ptr_r;
   logic [AW:0]  rd_ptr_r;
   logic         full_s;
   logic         empty_s;
   logic         push_s;
   logic         pop_s;

   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign push_s  = wr_en && !full_s;
   assign pop_s   = rd_en && !empty_s;

   assign full    = full_s;
   assign empty   = empty_s;
   assign level   = wr_ptr_r - rd_ptr_r;
   assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer registers; modular subtraction of the wide pointers gives occupancy.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Storage array, cleared so the head reads a known value while empty.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/v_instr_encoder.sv
// Vector instruction encoder/issuer: assembles RVV 1.0 words from field bundles and queues
// them for the coprocessor. Optional statistics counters: define V_INSTR_ENCODER_STATS_EN.
module v_instr_encoder
   import v_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [1:0]                 req_class,
   input  logic [2:0]                 req_f3,
   input  logic [5:0]                 req_op,
   input  logic                       req_vm,
   input  logic [4:0]                 req_vd,
   input  logic [4:0]                 req_src1,
   input  logic [4:0]                 req_src2,
   output logic [31:0]                instr_o,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic                       err_o,
   output logic [$clog2(DEPTH):0]     level_o
`ifdef V_INSTR_ENCODER_STATS_EN
   ,
   output logic [CNT_W-1:0]           cnt_ld_o,
   output logic [CNT_W-1:0]           cnt_st_o,
   output logic [CNT_W-1:0]           cnt_ar_o,
   output logic [CNT_W-1:0]           cnt_err_o
`endif
);

   v_class_e    class_s;
   logic [31:0] enc_word_s;
   logic        legal_s;
   logic        hs_s;
   logic        full_s;
   logic        empty_s;
   logic        err_r;

   assign class_s = v_class_e'(req_class);

   // Field packing and decoder-compatibility check for the presented bundle.
   always_comb begin
      enc_word_s = {req_op, req_vm, req_src2, req_src1, req_f3, req_vd, class_opcode(class_s)};
      legal_s    = is_legal(class_s, req_f3);
   end

   assign hs_s        = req_valid && !full_s;
   assign req_ready   = !full_s;
   assign instr_valid = !empty_s;
   assign err_o       = err_r;

   v_instr_fifo #(
      .DEPTH (DEPTH),
      .W     (32)
   ) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .wr_en   (hs_s && legal_s),
      .wr_data (enc_word_s),
      .rd_en   (instr_ready),
      .rd_data (instr_o),
      .full    (full_s),
      .empty   (empty_s),
      .level   (level_o)
   );

   // Rejection flag: high for exactly the cycle after an illegal handshake.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= hs_s && !legal_s;
      end
   end

`ifdef V_INSTR_ENCODER_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_ld_r;
   logic [CNT_W-1:0] cnt_st_r;
   logic [CNT_W-1:0] cnt_ar_r;
   logic [CNT_W-1:0] cnt_err_r;
   logic             pop_s;

   assign pop_s     = instr_valid && instr_ready;
   assign cnt_ld_o  = cnt_ld_r;
   assign cnt_st_o  = cnt_st_r;
   assign cnt_ar_o  = cnt_ar_r;
   assign cnt_err_o = cnt_err_r;

   // Saturating per-class pop counters, classified by the opcode actually issued.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_ld_r <= '0;
         cnt_st_r <= '0;
         cnt_ar_r <= '0;
      end else if (pop_s) begin
         case (instr_o[6:0])
            OPC_LTYPE: if (cnt_ld_r != CNT_MAX) cnt_ld_r <= cnt_ld_r + CNT_ONE;
            OPC_STYPE: if (cnt_st_r != CNT_MAX) cnt_st_r <= cnt_st_r + CNT_ONE;
            OPC_RTYPE: if (cnt_ar_r != CNT_MAX) cnt_ar_r <= cnt_ar_r + CNT_ONE;
            default:   cnt_ar_r <= cnt_ar_r;
         endcase
      end
   end

   // Saturating count of rejection pulses.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_err_r <= '0;
      end else if (err_r && (cnt_err_r != CNT_MAX)) begin
         cnt_err_r <= cnt_err_r + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_v_instr_encoder.sv
// Directed self-checking bench for v_instr_encoder (DEPTH=4).
module tb_v_instr_encoder;

   logic        clk;
   logic        nrst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_class;
   logic [2:0]  req_f3;
   logic [5:0]  req_op;
   logic        req_vm;
   logic [4:0]  req_vd;
   logic [4:0]  req_src1;
   logic [4:0]  req_src2;
   logic [31:0] instr_o;
   logic        instr_valid;
   logic        instr_ready;
   logic        err_o;
   logic [2:0]  level_o;
`ifdef V_INSTR_ENCODER_STATS_EN
   logic [15:0] cnt_ld_o;
   logic [15:0] cnt_st_o;
   logic [15:0] cnt_ar_o;
   logic [15:0] cnt_err_o;
`endif

   int checks;
   int failures;

   v_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_class   (req_class),
      .req_f3      (req_f3),
      .req_op      (req_op),
      .req_vm      (req_vm),
      .req_vd      (req_vd),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .instr_o     (instr_o),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .err_o       (err_o),
      .level_o     (level_o)
`ifdef V_INSTR_ENCODER_STATS_EN
      ,
      .cnt_ld_o    (cnt_ld_o),
      .cnt_st_o    (cnt_st_o),
      .cnt_ar_o    (cnt_ar_o),
      .cnt_err_o   (cnt_err_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input logic [1:0] c, input logic [2:0] f3, input logic [5:0] op,
                          input logic vm, input logic [4:0] vd, input logic [4:0] s1,
                          input logic [4:0] s2);
      req_class = c;
      req_f3    = f3;
      req_op    = op;
      req_vm    = vm;
      req_vd    = vd;
      req_src1  = s1;
      req_src2  = s2;
   endtask

   task automatic push(input logic [1:0] c, input logic [2:0] f3, input logic [5:0] op,
                       input logic vm, input logic [4:0] vd, input logic [4:0] s1,
                       input logic [4:0] s2);
      set_req(c, f3, op, vm, vd, s1, s2);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic pop();
      instr_ready = 1'b1;
      @(posedge clk); #1;
      instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0; req_valid = 1'b0; instr_ready = 1'b0;
      set_req(2'b00, 3'b000, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      #12;
      checks++;
      if (level_o !== 3'd0 || instr_valid !== 1'b0 || req_ready !== 1'b1 || err_o !== 1'b0 ||
          instr_o !== 32'h0) begin
         $display("FAIL reset_state level=%0d valid=%b ready=%b err=%b instr=%h expected 0 0 1 0 00000000",
                  level_o, instr_valid, req_ready, err_o, instr_o);
         failures++;
      end
      @(negedge clk); nrst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_encode();
      push(2'b10, 3'b000, 6'd0, 1'b1, 5'd3, 5'd1, 5'd2);
      checks++;
      if (instr_o !== 32'h022081D7 || instr_valid !== 1'b1 || err_o !== 1'b0 || level_o !== 3'd1) begin
         $display("FAIL arith_vv instr=%h valid=%b err=%b level=%0d expected 022081d7 1 0 1",
                  instr_o, instr_valid, err_o, level_o);
         failures++;
      end
      pop();
      checks++;
      if (instr_valid !== 1'b0 || level_o !== 3'd0) begin
         $display("FAIL pop_empty valid=%b level=%0d expected 0 0", instr_valid, level_o);
         failures++;
      end
      push(2'b10, 3'b011, 6'd0, 1'b1, 5'd4, 5'd7, 5'd5);
      checks++;
      if (instr_o !== 32'h0253B257 || instr_valid !== 1'b1) begin
         $display("FAIL arith_vi instr=%h valid=%b expected 0253b257 1", instr_o, instr_valid);
         failures++;
      end
      pop();
   endtask

   task automatic test_legality();
      push(2'b00, 3'b110, 6'd0, 1'b1, 5'd8, 5'd10, 5'd0);
      checks++;
      if (instr_o !== 32'h02056407 || level_o !== 3'd1 || err_o !== 1'b0) begin
         $display("FAIL load_e32 instr=%h level=%0d err=%b expected 02056407 1 0", instr_o, level_o, err_o);
         failures++;
      end
      push(2'b01, 3'b111, 6'd0, 1'b1, 5'd1, 5'd2, 5'd0);
      checks++;
      if (level_o !== 3'd2 || instr_o !== 32'h02056407) begin
         $display("FAIL store_push level=%0d head=%h expected 2 02056407", level_o, instr_o);
         failures++;
      end
      push(2'b10, 3'b001, 6'd0, 1'b1, 5'd1, 5'd1, 5'd1);
      checks++;
      if (err_o !== 1'b1 || level_o !== 3'd2) begin
         $display("FAIL arith_f3_001 err=%b level=%0d expected 1 2", err_o, level_o);
         failures++;
      end
      @(posedge clk); #1;
      checks++;
      if (err_o !== 1'b0) begin
         $display("FAIL err_one_cycle err=%b expected 0", err_o);
         failures++;
      end
      push(2'b11, 3'b000, 6'd0, 1'b1, 5'd1, 5'd1, 5'd1);
      checks++;
      if (err_o !== 1'b1 || level_o !== 3'd2) begin
         $display("FAIL class_rsvd err=%b level=%0d expected 1 2", err_o, level_o);
         failures++;
      end
      push(2'b01, 3'b001, 6'd0, 1'b1, 5'd1, 5'd1, 5'd1);
      checks++;
      if (err_o !== 1'b1 || level_o !== 3'd2) begin
         $display("FAIL store_f3_001 err=%b level=%0d expected 1 2", err_o, level_o);
         failures++;
      end
      pop();
      checks++;
      if (instr_o !== 32'h020170A7 || err_o !== 1'b0 || level_o !== 3'd1) begin
         $display("FAIL store_word instr=%h err=%b level=%0d expected 020170a7 0 1", instr_o, err_o, level_o);
         failures++;
      end
      pop();
   endtask

   task automatic test_full();
      logic [31:0] exp_w [5];
      exp_w[0] = 32'h020000D7; exp_w[1] = 32'h02000157; exp_w[2] = 32'h020001D7;
      exp_w[3] = 32'h02000257; exp_w[4] = 32'h020002D7;
      for (int i = 1; i <= 4; i++) begin
         push(2'b10, 3'b000, 6'd0, 1'b1, 5'(i), 5'd0, 5'd0);
      end
      checks++;
      if (level_o !== 3'd4 || req_ready !== 1'b0) begin
         $display("FAIL full_state level=%0d ready=%b expected 4 0", level_o, req_ready);
         failures++;
      end
      set_req(2'b10, 3'b000, 6'd0, 1'b1, 5'd5, 5'd0, 5'd0);
      req_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (level_o !== 3'd4 || req_ready !== 1'b0 || instr_o !== exp_w[0]) begin
         $display("FAIL held_req level=%0d ready=%b head=%h expected 4 0 %h", level_o, req_ready, instr_o, exp_w[0]);
         failures++;
      end
      instr_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (level_o !== 3'd3 || req_ready !== 1'b1 || instr_o !== exp_w[1]) begin
         $display("FAIL first_pop level=%0d ready=%b head=%h expected 3 1 %h", level_o, req_ready, instr_o, exp_w[1]);
         failures++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (level_o !== 3'd3 || instr_o !== exp_w[2]) begin
         $display("FAIL held_enters level=%0d head=%h expected 3 %h", level_o, instr_o, exp_w[2]);
         failures++;
      end
      for (int i = 2; i < 5; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_o !== exp_w[i]) begin
            $display("FAIL drain_order idx=%0d valid=%b head=%h expected 1 %h", i, instr_valid, instr_o, exp_w[i]);
            failures++;
         end
         @(posedge clk); #1;
      end
      instr_ready = 1'b0;
      checks++;
      if (level_o !== 3'd0 || instr_valid !== 1'b0) begin
         $display("FAIL drained level=%0d valid=%b expected 0 0", level_o, instr_valid);
         failures++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      push(2'b10, 3'b000, 6'd0, 1'b1, 5'd0, 5'd0, 5'd0);
      for (int k = 1; k <= 12; k++) begin
         exp = {6'(k - 1), 1'b1, 5'(k - 1), 5'd0, 3'b000, 5'(k - 1), 7'h57};
         checks++;
         if (instr_o !== exp || instr_valid !== 1'b1) begin
            $display("FAIL stream_order k=%0d head=%h expected %h", k, instr_o, exp);
            failures++;
         end
         set_req(2'b10, 3'b000, 6'(k), 1'b1, 5'(k), 5'd0, 5'(k));
         req_valid = 1'b1; instr_ready = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (level_o !== 3'd1) begin
            $display("FAIL stream_level k=%0d level=%0d expected 1", k, level_o);
            failures++;
         end
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      instr_ready = 1'b0;
      checks++;
      if (level_o !== 3'd0) begin
         $display("FAIL stream_drain level=%0d expected 0", level_o);
         failures++;
      end
   endtask

   task automatic test_midburst_reset();
      for (int i = 1; i <= 3; i++) begin
         push(2'b10, 3'b000, 6'd0, 1'b1, 5'(i), 5'd0, 5'd0);
      end
      checks++;
      if (level_o !== 3'd3) begin
         $display("FAIL pre_reset level=%0d expected 3", level_o);
         failures++;
      end
      set_req(2'b10, 3'b000, 6'd0, 1'b1, 5'd9, 5'd0, 5'd0);
      req_valid = 1'b1;
      #3 nrst = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || level_o !== 3'd0 || req_ready !== 1'b1 || instr_o !== 32'h0) begin
         $display("FAIL async_reset valid=%b level=%0d ready=%b instr=%h expected 0 0 1 00000000",
                  instr_valid, level_o, req_ready, instr_o);
         failures++;
      end
`ifdef V_INSTR_ENCODER_STATS_EN
      checks++;
      if (cnt_ld_o !== 16'd0 || cnt_st_o !== 16'd0 || cnt_ar_o !== 16'd0 || cnt_err_o !== 16'd0) begin
         $display("FAIL stats_reset ld=%0d st=%0d ar=%0d err=%0d expected all 0",
                  cnt_ld_o, cnt_st_o, cnt_ar_o, cnt_err_o);
         failures++;
      end
`endif
      req_valid = 1'b0;
      @(negedge clk); nrst = 1'b1;
      push(2'b10, 3'b000, 6'd0, 1'b1, 5'd10, 5'd0, 5'd0);
      checks++;
      if (instr_o !== 32'h02000557 || level_o !== 3'd1 || instr_valid !== 1'b1) begin
         $display("FAIL post_reset instr=%h level=%0d valid=%b expected 02000557 1 1",
                  instr_o, level_o, instr_valid);
         failures++;
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_encode();
      test_legality();
      test_full();
      test_back_to_back();
      test_midburst_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
